// File: rtl/wb_ram_bist_master.sv
// Purpose : Wishbone BIST master. Fills WORDS words from BASE_ADR with a pattern, then reads them back and compares.
// Latency : 2 cycles minimum per transfer; a zero-wait slave gives 4*WORDS+2 cycles from the start edge to done_o.
// Backpressure: one outstanding transaction; the request is held stable until ack and abandoned after TIMEOUT cycles.
// Ports   : wb_clk_i / wb_rstn_i clock and async active-low reset; start_i / seed_i run control;
//           wbm_* Wishbone master port; busy_o, done_o, pass_o, err_cnt_o, first_err_adr_o, timeout_o status.
// Option  : define BIST_LFSR_PATTERN_EN to use a 32-bit Galois LFSR pattern instead of the index XOR pattern.
module wb_ram_bist_master #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int unsigned WORDS    = 256,
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rstn_i,
  input  logic             start_i,
  input  logic [31:0]      seed_i,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [31:0]      first_err_adr_o,
  output logic             timeout_o
);

  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  localparam logic [15:0]   LAST_IDX = 16'(WORDS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WGAP, S_RD, S_RGAP, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic              start_q, start_qq;
  logic [31:0]       seed_q;
  logic [15:0]       idx;
  logic [TW-1:0]     wcnt;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [31:0]       first_err_q;
  logic              timeout_q, done_q, pass_q;
  logic              stb, we, busy;
  logic              start_edge, acked, last, tmo_hit, mismatch;
  logic [31:0]       cur_adr, pattern;

  assign start_edge = (state == S_IDLE) && start_q && !start_qq;
  assign acked      = stb && wbm_ack_i;
  assign last       = (idx == LAST_IDX);
  assign tmo_hit    = stb && !wbm_ack_i && (wcnt == TMO_LAST);
  assign cur_adr    = BASE_ADR + {14'd0, idx, 2'b00};
  assign mismatch   = (wbm_dat_i != pattern);

`ifdef BIST_LFSR_PATTERN_EN
  localparam logic [31:0] TAPS = 32'h8020_0003;
  logic [31:0] lfsr_q;

  // An all-zero state would lock the LFSR, so a zero seed starts from 1.
  function automatic logic [31:0] lfsr_init(input logic [31:0] s);
    return (s == 32'd0) ? 32'h0000_0001 : s;
  endfunction

  assign pattern = lfsr_q;

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      lfsr_q <= 32'd0;
    end else if (start_edge) begin
      lfsr_q <= lfsr_init(seed_i);
    end else if (acked) begin
      // The last write ack rewinds the sequence so the read phase sees the same words.
      if (state == S_WR && last)
        lfsr_q <= lfsr_init(seed_q);
      else
        lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'd0);
    end
  end
`else
  assign pattern = seed_q ^ {~idx, idx};
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // The gap states give the idle cycle between transfers. idx is back at 0
  // only after the last word of a phase, which selects the next phase.
  always_comb begin
    state_nxt = state;
    stb       = 1'b0;
    we        = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: if (start_edge) state_nxt = S_WR;
      S_WR: begin
        stb  = 1'b1;
        we   = 1'b1;
        busy = 1'b1;
        if (wbm_ack_i)              state_nxt = S_WGAP;
        else if (wcnt == TMO_LAST)  state_nxt = S_DONE;
      end
      S_WGAP: begin
        busy      = 1'b1;
        state_nxt = (idx == 16'd0) ? S_RD : S_WR;
      end
      S_RD: begin
        stb  = 1'b1;
        busy = 1'b1;
        if (wbm_ack_i)              state_nxt = S_RGAP;
        else if (wcnt == TMO_LAST)  state_nxt = S_DONE;
      end
      S_RGAP: begin
        busy      = 1'b1;
        state_nxt = (idx == 16'd0) ? S_DONE : S_RD;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      start_q     <= 1'b0;
      start_qq    <= 1'b0;
      seed_q      <= 32'd0;
      idx         <= 16'd0;
      wcnt        <= '0;
      err_cnt_q   <= '0;
      first_err_q <= 32'd0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      start_q  <= start_i;
      start_qq <= start_q;

      // Wait counter restarts with every request since stb always drops between transfers.
      if (!stb || wbm_ack_i)    wcnt <= '0;
      else if (wcnt != TMO_LAST) wcnt <= wcnt + TW'(1);

      if (start_edge) begin
        seed_q      <= seed_i;
        idx         <= 16'd0;
        err_cnt_q   <= '0;
        first_err_q <= 32'd0;
        timeout_q   <= 1'b0;
        done_q      <= 1'b0;
        pass_q      <= 1'b0;
      end

      if (acked) idx <= last ? 16'd0 : idx + 16'd1;

      if (state == S_RD && acked && mismatch) begin
        if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_q <= err_cnt_q + CNT_W'(1);
        if (err_cnt_q == '0)            first_err_q <= cur_adr;
      end

      if (tmo_hit) timeout_q <= 1'b1;

      if (state == S_DONE) begin
        done_q <= 1'b1;
        pass_q <= (err_cnt_q == '0) && !timeout_q;
      end
    end
  end

  // Bus outputs are decoded from state so an asynchronous reset drops them at once.
  assign wbm_cyc_o       = stb;
  assign wbm_stb_o       = stb;
  assign wbm_we_o        = we;
  assign wbm_sel_o       = stb ? 4'hF : 4'h0;
  assign wbm_adr_o       = stb ? cur_adr : 32'd0;
  assign wbm_dat_o       = (stb && we) ? pattern : 32'd0;
  assign busy_o          = busy;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign err_cnt_o       = err_cnt_q;
  assign first_err_adr_o = first_err_q;
  assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_wb_ram_bist_master.sv
`timescale 1ns/1ps
module tb_wb_ram_bist_master;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_i;
  logic [31:0] seed_i;
  logic        cyc, stb, we, ack, busy, done, pass, tmo;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i, first_err;
  logic [15:0] err_cnt;

  logic        cyc2, stb2, we2, ack2, busy2, done2, pass2, tmo2;
  logic [3:0]  sel2;
  logic [31:0] adr2, dat_o2, dat_i2, first2;
  logic [15:0] err2;

  always #5 clk = ~clk;

  wb_ram_bist_master #(.BASE_ADR(32'h3000_0000), .WORDS(W), .TIMEOUT(8), .CNT_W(16)) u_dut (
    .wb_clk_i(clk), .wb_rstn_i(rstn), .start_i(start_i), .seed_i(seed_i),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
    .busy_o(busy), .done_o(done), .pass_o(pass), .err_cnt_o(err_cnt),
    .first_err_adr_o(first_err), .timeout_o(tmo));

  // Second instance straddles the top of the address space to exercise wrap-around.
  wb_ram_bist_master #(.BASE_ADR(32'hFFFF_FFFC), .WORDS(2), .TIMEOUT(8), .CNT_W(16)) u_dut2 (
    .wb_clk_i(clk), .wb_rstn_i(rstn), .start_i(start_i), .seed_i(seed_i),
    .wbm_cyc_o(cyc2), .wbm_stb_o(stb2), .wbm_we_o(we2), .wbm_sel_o(sel2),
    .wbm_adr_o(adr2), .wbm_dat_o(dat_o2), .wbm_dat_i(dat_i2), .wbm_ack_i(ack2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_cnt_o(err2),
    .first_err_adr_o(first2), .timeout_o(tmo2));

  // Slave 1: mode 0 zero-wait, 1 registered decode + 3 waits (ack on 5th strobe cycle),
  // 2 never acks word 1, 3 ack held high permanently. stuck[] forces read bits low.
  int          mode = 0;
  int          scnt = 0;
  logic [31:0] mem   [4];
  logic [31:0] stuck [4];

  assign ack   = (mode == 3) ? 1'b1 :
                 (mode == 1) ? (stb && scnt == 4) :
                 (mode == 2) ? (stb && adr != 32'h3000_0004) : stb;
  assign dat_i = mem[adr[3:2]] & ~stuck[adr[3:2]];

  always @(posedge clk) begin
    if (stb && we && ack) mem[adr[3:2]] <= dat_o;
    if (!stb || ack) scnt <= 0;
    else             scnt <= scnt + 1;
  end

  logic [31:0] mem2 [2];
  assign ack2   = stb2;
  assign dat_i2 = mem2[adr2[2]];
  always @(posedge clk) if (stb2 && we2) mem2[adr2[2]] <= dat_o2;

  // Monitor: write log, cycles spent on word 1, request stability during waits.
  int          wr_n = 0, wr2_n = 0, w1_cyc = 0, unstable = 0, waits = 0;
  logic [31:0] wr_adr [128];
  logic [31:0] wr_dat [128];
  logic [31:0] wr2_adr [8];
  logic [31:0] hold_adr, hold_dat;

  always @(negedge clk) begin
    if (stb && we && ack && wr_n < 128) begin
      wr_adr[wr_n] <= adr;
      wr_dat[wr_n] <= dat_o;
      wr_n         <= wr_n + 1;
    end
    if (stb2 && we2 && wr2_n < 8) begin
      wr2_adr[wr2_n] <= adr2;
      wr2_n          <= wr2_n + 1;
    end
    if (cyc && adr == 32'h3000_0004) w1_cyc <= w1_cyc + 1;
    if (stb) begin
      if (scnt == 0) begin
        hold_adr <= adr;
        hold_dat <= dat_o;
      end else begin
        waits <= waits + 1;
        if (adr != hold_adr || dat_o != hold_dat) unstable <= unstable + 1;
      end
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Raises start_i and counts cycles from the start-edge detect cycle until done_o.
  task automatic run(input logic [31:0] seed, output int cycles);
    int n;
    @(negedge clk);
    seed_i  = seed;
    start_i = 1'b1;
    cycles  = -1;
    for (n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (n >= 2 && done) begin
        cycles = n - 1;
        break;
      end
    end
    chk("run_done", 32'(done), 32'd1);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  logic [31:0] exp_dat [4];
  int          cyc_n, base, w1_snap, n;

  initial begin
`ifdef BIST_LFSR_PATTERN_EN
    exp_dat = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001};
`else
    exp_dat = '{32'hFFFF_0000, 32'hFFFE_0001, 32'hFFFD_0002, 32'hFFFC_0003};
`endif
    stuck   = '{32'd0, 32'd0, 32'd0, 32'd0};
    rstn    = 1'b0;
    start_i = 1'b0;
    seed_i  = 32'd0;

    // Reset state
    #12;
    chk("rst_cyc",  32'(cyc),  32'd0);
    chk("rst_stb",  32'(stb),  32'd0);
    chk("rst_sel",  32'(sel),  32'd0);
    chk("rst_adr",  adr,       32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err",  32'(err_cnt), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait clean run, seed 0
    mode = 0;
    base = wr_n;
    run(32'd0, cyc_n);
    chk("t1_cycles", 32'(cyc_n), 32'(4 * W + 2));
    chk("t1_pass",   32'(pass), 32'd1);
    chk("t1_err",    32'(err_cnt), 32'd0);
    chk("t1_first",  first_err, 32'd0);
    chk("t1_tmo",    32'(tmo), 32'd0);
    chk("t1_busy",   32'(busy), 32'd0);
    chk("t1_nwr",    32'(wr_n - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_adr%0d", i), wr_adr[base + i], 32'h3000_0000 + 32'(4 * i));
      chk($sformatf("t1_dat%0d", i), wr_dat[base + i], exp_dat[i]);
    end
    chk("wrap_pass", 32'(pass2), 32'd1);
    chk("wrap_adr0", wr2_adr[0], 32'hFFFF_FFFC);
    chk("wrap_adr1", wr2_adr[1], 32'h0000_0000);

    // Stuck-at-0 on a bit that is 1 in word 2's pattern
    stuck[2] = 32'h0020_0000;
    run(32'd0, cyc_n);
    chk("f1_err",   32'(err_cnt), 32'd1);
    chk("f1_first", first_err, 32'h3000_0008);
    chk("f1_pass",  32'(pass), 32'd0);

    // Two faulty words: count 2, first address is the earlier one
    stuck = '{32'd0, 32'h0000_00FF, 32'd0, 32'h0000_00FF};
    run(32'hA5A5_5A5A, cyc_n);
    chk("f2_err",   32'(err_cnt), 32'd2);
    chk("f2_first", first_err, 32'h3000_0004);
    chk("f2_pass",  32'(pass), 32'd0);
    stuck = '{32'd0, 32'd0, 32'd0, 32'd0};

    // Wait states: 6 cycles per transfer
    mode = 1;
    run(32'h1234_5678, cyc_n);
    chk("ws_cycles",   32'(cyc_n), 32'(12 * W + 2));
    chk("ws_pass",     32'(pass), 32'd1);
    chk("ws_stable",   32'(unstable), 32'd0);
    chk("ws_waits_on", 32'(waits > 0), 32'd1);

    // Ack held high also in gap cycles must be ignored
    mode = 3;
    run(32'h0BAD_F00D, cyc_n);
    chk("fa_cycles", 32'(cyc_n), 32'(4 * W + 2));
    chk("fa_pass",   32'(pass), 32'd1);
    chk("fa_err",    32'(err_cnt), 32'd0);

    // Slave never acks word 1
    mode    = 2;
    w1_snap = w1_cyc;
    run(32'd0, cyc_n);
    chk("to_cyc_len", 32'(w1_cyc - w1_snap), 32'd8);
    chk("to_flag",    32'(tmo), 32'd1);
    chk("to_pass",    32'(pass), 32'd0);
    chk("to_err",     32'(err_cnt), 32'd0);

    // Asynchronous reset during the read phase
    mode = 0;
    @(negedge clk);
    seed_i  = 32'h0F0F_F0F0;
    start_i = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (stb && !we) break;
    end
    chk("ar_in_rd", 32'(stb && !we), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("ar_cyc",  32'(cyc),  32'd0);
    chk("ar_stb",  32'(stb),  32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    run(32'h0F0F_F0F0, cyc_n);
    chk("ar_cycles", 32'(cyc_n), 32'(4 * W + 2));
    chk("ar_pass",   32'(pass), 32'd1);
    chk("ar_tmo",    32'(tmo), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
